fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Drains bytes from the sync FIFO read port and serialises them as UART frames:
//  start bit, DATA_WIDTH data bits LSB first, optional parity bit, 1 or 2 stop bits.
//  Sits directly downstream of the FIFO top.
//  Reads only when the FIFO is non-empty, so it never raises the FIFO underflow flag.
// PARAMETERS
//  DATA_WIDTH   8            bits per frame; matches the FIFO data width
//  CLK_FREQ_HZ  100_000_000  clk frequency
//  BAUD         115_200      line rate
//  PARITY_EN    0            1 = append a parity bit
//  PARITY_ODD   0            0 = even parity, 1 = odd parity (only used when PARITY_EN=1)
//  STOP_BITS    1            1 or 2
//  localparam CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division); elaboration error if < 4
// PORTS
//  clk         in   1           single clock; all logic on posedge
//  rst_n       in   1           asynchronous, active-low reset
//  enable      in   1           1 = allowed to start new frames
//  fifo_empty  in   1           FIFO empty flag
//  fifo_rd_en  out  1           one-clk read strobe to the FIFO
//  fifo_data   in   DATA_WIDTH  FIFO data_out; valid one clk after fifo_rd_en
//  tx          out  1           serial line; idles high
//  busy        out  1           high from the fetch until the end of the last stop bit
//  frame_done  out  1           one-clk pulse when the last stop bit ends
// BEHAVIOUR
//  Reset (async, rst_n=0) sets: tx=1, fifo_rd_en=0, busy=0, frame_done=0,
//  state=IDLE, baud counter=0, bit index=0. All outputs are registered.
//  States: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: if enable && !fifo_empty at edge N, go to FETCH. fifo_rd_en=1 for cycle N..N+1 only.
//  LOAD: one cycle. At edge N+2, capture fifo_data into the shift reg, compute parity
//    (XOR of data bits, inverted if PARITY_ODD), then enter START. tx=0 from edge N+2.
//  Bit timing: every START/DATA/PARITY/STOP bit holds tx for exactly CLKS_PER_BIT clks.
//    The baud counter runs 0..CLKS_PER_BIT-1 and the bit advances on terminal count.
//  DATA: shift out LSB first; after bit DATA_WIDTH-1, go to PARITY if PARITY_EN, else STOP.
//  STOP: tx=1 for STOP_BITS*CLKS_PER_BIT clks. On the final terminal count:
//    - frame_done pulses
//    - busy drops
//    - state returns to IDLE
//  Frame length = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT clks, plus 2 clks fetch.
//  Back-to-back frames: IDLE re-evaluates on the next edge, so consecutive start bits are
//    separated by a fixed 3-clk extra high gap (IDLE+FETCH+LOAD). No prefetch.
//  enable low mid-frame: the current frame completes; no further fetch.
//  enable low in FETCH/LOAD: the byte is already popped, so the frame is still sent.
//  fifo_empty is sampled only in IDLE; fifo_rd_en is never asserted while fifo_empty=1.
//  Reset mid-frame: tx returns high immediately and the in-flight byte is lost.
//    The FIFO is not re-read for that byte.
//  fifo_data is ignored outside the LOAD capture edge.
// STRUCTURE
//  uart_defs.vh (shared include): state encodings and parity mode localparams.
//    Reused by the future UART RX.
//  Sub-module uart_baud_gen: clr/en inputs, CLKS_PER_BIT counter, one-clk tick output.
//    Shared with the RX (instanced at mid-bit).
//  Top-level FSM, shift reg and bit index live in fifo_uart_tx.
// TESTING (CLK_FREQ_HZ=1_600_000, BAUD=100_000 -> CLKS_PER_BIT=16; paired with fifo_sync_top)
//  1. Push 0xA5, enable=1.
//     -> tx low 2 clks after !empty is sampled.
//     -> line bits 0,1,0,1,0,0,1,0,1,1 at 16 clks each.
//     -> frame_done pulses once at 162 clks.
//  2. Push 0x00,0xFF,0x3C back-to-back.
//     -> 3 frames, each 160 clks, with 3-clk gaps.
//     -> FIFO empty after the third fetch; underflow stays 0.
//  3. PARITY_EN=1: 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
//     -> frame is 176 clks.
//  4. STOP_BITS=2, enable dropped during DATA of frame 1 with 2 bytes queued.
//     -> frame 1 completes with 32 high clks; no second fetch; FIFO keeps 1 entry.
//  5. rst_n pulsed low mid-DATA.
//     -> tx=1 and busy=0 asynchronously.
//     -> after release, the next queued byte is sent as a clean full frame.
//  6. enable=1 with the FIFO empty for 1000 clks.
//     -> fifo_rd_en never asserts, tx stays 1, busy stays 0.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART TX/RX definitions: FSM states, parity modes, bit timing.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MIN_CLKS_PER_BIT = 4;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the UART TX.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter; tick marks the last clk of each bit.
module fifo_uart_tx_baud_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_cpb_chk
    $error("CLKS_PER_BIT below minimum");
  end

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the sync FIFO and sends them as UART frames.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int CLKS_PER_BIT =
    clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic PAR_MODE =
    (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("STOP_BITS must be 1 or 2");
  end

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  tx_d, busy_d, done_d, rd_d;
  logic                  tick, bit_on;

  assign bit_on = state_q inside
    {S_START, S_DATA, S_PARITY, S_STOP};

  fifo_uart_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == S_LOAD),
    .en   (bit_on),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      shift_q         <= '0;
      idx_q           <= '0;
      par_q           <= 1'b0;
      tx              <= 1'b1;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      fifo.fifo_rd_en <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      idx_q           <= idx_d;
      par_q           <= par_d;
      tx              <= tx_d;
      busy            <= busy_d;
      frame_done      <= done_d;
      fifo.fifo_rd_en <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx;
    busy_d  = busy;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo.fifo_empty) begin
          state_d = S_FETCH;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = fifo.fifo_data;
        par_d   = (^fifo.fifo_data) ^ PAR_MODE;
        idx_d   = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: if (tick) begin
        tx_d    = shift_q[0];
        state_d = S_DATA;
      end
      S_DATA: if (tick) begin
        if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
          idx_d = '0;
          if (PARITY_EN != 0) begin
            tx_d    = par_q;
            state_d = S_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end
        end else begin
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
          idx_d   = idx_q + 1'b1;
        end
      end
      S_PARITY: if (tick) begin
        tx_d    = 1'b1;
        state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        if (idx_q == IDX_W'(STOP_BITS - 1)) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: four UART TX variants fed by a FIFO model.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en     [4];
  logic       tx     [4];
  logic       busy   [4];
  logic       done   [4];
  logic       rd_en  [4];
  logic [7:0] dout   [4];
  logic [7:0] mem    [4][8];
  int         wp     [4];
  int         rp     [4];
  int         rd_cnt [4];
  int         uf     [4];
  int         dn_cnt [4];
  int         cyc;
  int         checks;
  int         errors;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    localparam int PE = (g == 1 || g == 2) ? 1 : 0;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 3) ? 2 : 1;
    fifo_uart_tx_if #(.DATA_WIDTH(8)) bus ();
    assign bus.fifo_empty = (wp[g] == rp[g]);
    assign bus.fifo_data  = dout[g];
    assign rd_en[g]       = bus.fifo_rd_en;
    fifo_uart_tx #(
      .DATA_WIDTH (8),
      .CLK_FREQ_HZ(1_600_000),
      .BAUD       (100_000),
      .PARITY_EN  (PE),
      .PARITY_ODD (PO),
      .STOP_BITS  (SB)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (en[g]),
      .fifo      (bus),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .frame_done(done[g])
    );
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (rd_en[i]) begin
        rd_cnt[i] <= rd_cnt[i] + 1;
        if (wp[i] == rp[i]) begin
          uf[i] <= uf[i] + 1;
        end else begin
          dout[i] <= mem[i][rp[i] % 8];
          rp[i]   <= rp[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done[i] === 1'b1) dn_cnt[i] <= dn_cnt[i] + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wp[i] % 8] = b;
    wp[i] = wp[i] + 1;
  endtask

  // n = edge at which IDLE samples the non-empty FIFO
  task automatic check_frame(
    input int          i,
    input int          n,
    input logic [11:0] exp,
    input int          nbits
  );
    int len;
    len = nbits * 16;
    wait_until(n);
    chk("rd_en_hi", rd_en[i], 1);
    chk("tx_idle", tx[i], 1);
    wait_until(n + 1);
    chk("rd_en_lo", rd_en[i], 0);
    chk("tx_fetch", tx[i], 1);
    chk("busy_fetch", busy[i], 1);
    wait_until(n + 2);
    chk("tx_start", tx[i], 0);
    for (int k = 0; k < nbits; k++) begin
      wait_until(n + 2 + 16 * k + 8);
      chk($sformatf("i%0d_bit%0d", i, k), tx[i], exp[k]);
    end
    wait_until(n + 1 + len);
    chk("busy_end", busy[i], 1);
    chk("done_early", done[i], 0);
    wait_until(n + 2 + len);
    chk("done", done[i], 1);
    chk("busy_drop", busy[i], 0);
    chk("tx_stop", tx[i], 1);
  endtask

  initial begin
    int n;
    int d0;
    int r, t, b;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i]     = 1'b0;
      wp[i]     = 0;
      rp[i]     = 0;
      rd_cnt[i] = 0;
      uf[i]     = 0;
      dn_cnt[i] = 0;
      dout[i]   = '0;
    end
    cyc = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", tx[i], 1);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_rd_en", rd_en[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // single 0xA5 frame
    en[0] = 1'b1;
    push(0, 8'hA5);
    n  = cyc + 1;
    d0 = dn_cnt[0];
    check_frame(0, n, {1'b1, 8'hA5, 1'b0}, 10);
    wait_until(n + 170);
    chk("done_once", dn_cnt[0] - d0, 1);

    // back-to-back frames
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    n = cyc + 1;
    check_frame(0, n, {1'b1, 8'h00, 1'b0}, 10);
    check_frame(0, n + 163, {1'b1, 8'hFF, 1'b0}, 10);
    check_frame(0, n + 326, {1'b1, 8'h3C, 1'b0}, 10);
    chk("b2b_empty", wp[0] == rp[0], 1);
    chk("b2b_reads", rd_cnt[0], 4);
    chk("b2b_uflow", uf[0], 0);
    en[0] = 1'b0;

    // parity even then odd
    en[1] = 1'b1;
    push(1, 8'h07);
    n = cyc + 1;
    check_frame(1, n, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    en[1] = 1'b0;
    en[2] = 1'b1;
    push(2, 8'h07);
    n = cyc + 1;
    check_frame(2, n, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    en[2] = 1'b0;

    // two stop bits, enable dropped mid-DATA
    en[3] = 1'b1;
    push(3, 8'h5A);
    push(3, 8'hC3);
    n = cyc + 1;
    fork
      check_frame(3, n, {2'b11, 8'h5A, 1'b0}, 11);
      begin
        wait_until(n + 60);
        en[3] = 1'b0;
      end
    join
    wait_until(cyc + 40);
    chk("sb2_reads", rd_cnt[3], 1);
    chk("sb2_level", wp[3] - rp[3], 1);
    chk("sb2_busy", busy[3], 0);
    chk("sb2_tx", tx[3], 1);

    // async reset mid-DATA
    en[0] = 1'b1;
    push(0, 8'h81);
    push(0, 8'h42);
    n = cyc + 1;
    wait_until(n + 2 + 16 + 8);
    chk("pre_rst_bit0", tx[0], 1);
    wait_until(n + 2 + 64 + 4);
    chk("pre_rst_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", tx[0], 1);
    chk("arst_busy", busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = cyc + 1;
    check_frame(0, n, {1'b1, 8'h42, 1'b0}, 10);
    chk("rst_reads", rd_cnt[0], 6);
    chk("rst_empty", wp[0] == rp[0], 1);

    // enabled with empty FIFO
    r = 0;
    t = 0;
    b = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rd_en[0]) r++;
      if (!tx[0]) t++;
      if (busy[0]) b++;
    end
    chk("idle_rd_en", r, 0);
    chk("idle_tx_low", t, 0);
    chk("idle_busy", b, 0);
    chk("uflow_all", uf[0] + uf[1] + uf[2] + uf[3], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
